pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning: MEM_WAIT cycles without mem_ack_i before a bus error; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 stallreq_id_i  input  1  decode-stage stall request (load-use hazard).
REQ-005 stallreq_ex_i  input  1  execute-stage stall request (madd/msub second cycle, divider busy).
REQ-006 mem_req_i  input  1  MEM stage holds a load/store needing the data bus.
REQ-007 mem_ack_i  input  1  data bus completes the current access this cycle.
REQ-008 excepttype_i  input  32  exception code from MEM stage; zero means none.
REQ-009 cp0_epc_i  input  32  EPC value used for eret.
REQ-010 cnt_clr_i  input  1  clears the stall-cycle counter.
REQ-011 stall  output  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = Stop.
REQ-012 flush  output  1  flush all pipeline registers this cycle.
REQ-013 new_pc  output  32  exception handler address, valid while flush=1.
REQ-014 bus_err_o  output  1  one-cycle pulse: data bus timeout.
REQ-015 stall_cnt_o  output  32  number of cycles with stall[0]=1.

Function
REQ-016 States: IDLE, MEM_WAIT, BUS_ERR; 8-bit wait counter wcnt.
REQ-017 Priority, highest first: rst, exception, bus-wait stall, EX stall, ID stall.
REQ-018 Stall patterns: exception/BUS_ERR 6'b000000; bus wait 6'b011111; EX 6'b001111; ID 6'b000111; none 6'b000000.
REQ-019 Stall, flush and new_pc are combinational from current state and inputs within the same cycle.
REQ-020 flush=1 exactly when excepttype_i != 0 and rst=0; stall=0 whenever flush=1.
REQ-021 new_pc by excepttype_i: 0x00000001 -> 0x00000020; 0x00000008, 0x0000000a, 0x0000000c, 0x0000000d -> 0x00000040; 0x0000000e -> cp0_epc_i; other nonzero -> 0x00000040; zero -> 0x00000000.
REQ-022 Bus-wait condition: (state=IDLE or MEM_WAIT) and mem_req_i=1 and mem_ack_i=0.
REQ-023 IDLE: bus-wait condition and no exception -> MEM_WAIT, wcnt<=1; mem_ack_i=1 in the same cycle -> no stall, stay IDLE.
REQ-024 MEM_WAIT: mem_ack_i=1 -> bus stall released that cycle, next state IDLE, wcnt<=0.
REQ-025 MEM_WAIT: mem_req_i=0 -> bus stall released that cycle, next IDLE, wcnt<=0.
REQ-026 MEM_WAIT with no ack: wcnt=TIMEOUT -> next BUS_ERR, wcnt<=0; otherwise wcnt<=wcnt+1.
REQ-027 BUS_ERR lasts exactly one cycle: bus_err_o=1, stall=0, ignores mem_req_i, next IDLE.
REQ-028 Exception in any state -> next IDLE, wcnt<=0, bus_err_o=0 that cycle.
REQ-029 Stall/ack collision: ack and timeout in the same cycle -> ack wins, no bus_err_o.
REQ-030 stall_cnt_o increments on each cycle with stall[0]=1 and saturates at 0xFFFFFFFF; cnt_clr_i=1 loads 0, overriding the increment.
REQ-031 stall[3]=1 with stall[4]=0 (EX/ID stall) means EX/MEM inserts a bubble; stall[4]=1 holds EX/MEM contents.

Reset
REQ-032 While rst=1: state IDLE, wcnt=0, stall=0, flush=0, new_pc=0, bus_err_o=0, stall_cnt_o=0, all inputs ignored.
REQ-033 rst asserted mid-MEM_WAIT aborts the wait; first cycle after release starts in IDLE.

Verification
REQ-034 stallreq_id_i=1 one cycle -> stall=000111 that cycle; with stallreq_ex_i=1 also -> 001111; stall_cnt_o +1.
REQ-035 mem_req_i=1, ack on 4th cycle -> stall=011111 for 3 cycles, 000000 on the ack cycle, state IDLE next, stall_cnt_o=3.
REQ-036 TIMEOUT=4, mem_req_i held, no ack -> 5 stalled cycles, then bus_err_o=1 for 1 cycle with stall=0, then IDLE.
REQ-037 In MEM_WAIT, excepttype_i=0x0000000e, cp0_epc_i=0x00001234 -> flush=1, new_pc=0x00001234, stall=0, next IDLE.
REQ-038 mem_ack_i and timeout in the same cycle -> no bus_err_o; stall_cnt_o at 0xFFFFFFFF stays; cnt_clr_i=1 -> 0.
REQ-039 rst=1 during MEM_WAIT with stall_cnt_o=7 -> all outputs 0 next cycle, IDLE.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall / flush controller.
// Merges per-stage stall requests, data-bus wait and exception flush into
// one per-stage hold vector. A bus wait with no ack times out into a
// one-cycle bus error. A saturating counter records how many cycles the
// PC was held.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | no outstanding bus wait
// S_MEM_WAIT | MEM stage waiting on data bus ack, wcnt counts wait cycles
// S_BUS_ERR  | one-cycle bus timeout report, pipeline released
module pipe_stall_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        mem_req_i,
  input  logic        mem_ack_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        cnt_clr_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_err_o,
  output logic [31:0] stall_cnt_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_BUS_ERR  = 2'd2;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  localparam logic [5:0] STALL_BUS  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  localparam logic [31:0] VEC_INT  = 32'h0000_0020;
  localparam logic [31:0] VEC_GEN  = 32'h0000_0040;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  logic [1:0]  state_q, state_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [31:0] cnt_q;
  logic        exc;
  logic        bus_wait;

  // Qualify exception and bus-wait conditions; reset masks everything.
  always_comb begin
    exc      = !rst && (excepttype_i != '0);
    bus_wait = !rst && ((state_q == S_IDLE) || (state_q == S_MEM_WAIT)) &&
               mem_req_i && !mem_ack_i;
  end

  // Per-stage hold vector by priority: exception, bus wait, EX, ID.
  always_comb begin
    stall = STALL_NONE;
    if (rst || exc || (state_q == S_BUS_ERR)) begin
      stall = STALL_NONE;
    end else if (bus_wait) begin
      stall = STALL_BUS;
    end else if (stallreq_ex_i) begin
      stall = STALL_EX;
    end else if (stallreq_id_i) begin
      stall = STALL_ID;
    end
  end

  // Flush and handler address; eret returns to EPC, everything else
  // except the interrupt code uses the general vector.
  always_comb begin
    flush  = exc;
    new_pc = '0;
    if (exc) begin
      case (excepttype_i)
        EXC_INT:  new_pc = VEC_INT;
        EXC_ERET: new_pc = cp0_epc_i;
        default:  new_pc = VEC_GEN;
      endcase
    end
  end

  // Next-state and wait-counter logic; an ack always beats the timeout.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    if (exc) begin
      state_d = S_IDLE;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_wait) begin
            state_d = S_MEM_WAIT;
            wcnt_d  = 8'd1;
          end
        end
        S_MEM_WAIT: begin
          if (!mem_req_i || mem_ack_i) begin
            state_d = S_IDLE;
            wcnt_d  = '0;
          end else if (wcnt_q == TIMEOUT_C) begin
            state_d = S_BUS_ERR;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 8'd1;
          end
        end
        S_BUS_ERR: begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end
        default: begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end
      endcase
    end
  end

  // State, wait counter and saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (cnt_clr_i) begin
        cnt_q <= '0;
      end else if (stall[0] && (cnt_q != '1)) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  // Outputs read zero for the whole time reset is held.
  always_comb begin
    bus_err_o   = !rst && !exc && (state_q == S_BUS_ERR);
    stall_cnt_o = rst ? '0 : cnt_q;
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl (TIMEOUT=4).
module tb_pipe_stall_ctrl;

  localparam logic [5:0] ST_BUS = 6'b011111;
  localparam logic [5:0] ST_EX  = 6'b001111;
  localparam logic [5:0] ST_ID  = 6'b000111;
  localparam logic [5:0] ST_Z   = 6'b000000;

  logic        clk;
  logic        rst;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        mem_req_i;
  logic        mem_ack_i;
  logic [31:0] excepttype_i;
  logic [31:0] cp0_epc_i;
  logic        cnt_clr_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_err_o;
  logic [31:0] stall_cnt_o;

  pipe_stall_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stallreq_id_i(stallreq_id_i),
    .stallreq_ex_i(stallreq_ex_i),
    .mem_req_i    (mem_req_i),
    .mem_ack_i    (mem_ack_i),
    .excepttype_i (excepttype_i),
    .cp0_epc_i    (cp0_epc_i),
    .cnt_clr_i    (cnt_clr_i),
    .stall        (stall),
    .flush        (flush),
    .new_pc       (new_pc),
    .bus_err_o    (bus_err_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {rst, stallreq_id, stallreq_ex, mem_req, mem_ack}
  typedef struct {
    string       name;
    logic [4:0]  ctl;
    logic [31:0] exc;
    logic [31:0] epc;
    logic        clr;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_berr;
  } vec_t;

  typedef struct {
    string       name;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        berr;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] cnt_model;
  int          nvec;
  int          nmis;
  vec_t        tbl[16];

  task automatic check();
    exp_t e;
    nvec++;
    if (sb.size() == 0) begin
      nmis++;
      $display("FAIL scoreboard_empty: no expected record queued");
      return;
    end
    e = sb.pop_front();
    if (stall !== e.stall || flush !== e.flush || new_pc !== e.pc ||
        bus_err_o !== e.berr || stall_cnt_o !== e.cnt) begin
      nmis++;
      $display("FAIL %s: got stall=%b flush=%b new_pc=%h bus_err=%b cnt=%h, want stall=%b flush=%b new_pc=%h bus_err=%b cnt=%h",
               e.name, stall, flush, new_pc, bus_err_o, stall_cnt_o,
               e.stall, e.flush, e.pc, e.berr, e.cnt);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare mid-cycle.
  task automatic go(input vec_t v);
    exp_t e;
    {rst, stallreq_id_i, stallreq_ex_i, mem_req_i, mem_ack_i} = v.ctl;
    excepttype_i = v.exc;
    cp0_epc_i    = v.epc;
    cnt_clr_i    = v.clr;
    e.name  = v.name;
    e.stall = v.e_stall;
    e.flush = v.e_flush;
    e.pc    = v.e_pc;
    e.berr  = v.e_berr;
    e.cnt   = v.ctl[4] ? 32'h0 : cnt_model;
    sb.push_back(e);
    if (v.ctl[4] || v.clr) cnt_model = 32'h0;
    else if (v.e_stall[0] && cnt_model != 32'hFFFF_FFFF) cnt_model = cnt_model + 32'd1;
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic s(input string n, input logic [4:0] ctl, input logic [31:0] exc,
                   input logic [31:0] epc, input logic clr, input logic [5:0] st,
                   input logic fl, input logic [31:0] pc, input logic be);
    vec_t v;
    v.name = n; v.ctl = ctl; v.exc = exc; v.epc = epc; v.clr = clr;
    v.e_stall = st; v.e_flush = fl; v.e_pc = pc; v.e_berr = be;
    go(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    nvec = 0;
    nmis = 0;
    cnt_model = 32'h0;
    rst = 1'b1; stallreq_id_i = 1'b0; stallreq_ex_i = 1'b0;
    mem_req_i = 1'b0; mem_ack_i = 1'b0; excepttype_i = 32'h0;
    cp0_epc_i = 32'h0; cnt_clr_i = 1'b0;

    // Single-cycle behaviour from IDLE
    tbl[0]  = '{"idle_epc_no_exc", 5'b00000, 32'h0,        32'h0000_1234, 1'b0, ST_Z,  1'b0, 32'h0,         1'b0};
    tbl[1]  = '{"id_stall",        5'b01000, 32'h0,        32'h0,         1'b0, ST_ID, 1'b0, 32'h0,         1'b0};
    tbl[2]  = '{"id_ex_stall",     5'b01100, 32'h0,        32'h0,         1'b0, ST_EX, 1'b0, 32'h0,         1'b0};
    tbl[3]  = '{"ex_stall",        5'b00100, 32'h0,        32'h0,         1'b0, ST_EX, 1'b0, 32'h0,         1'b0};
    tbl[4]  = '{"req_ack_same",    5'b00011, 32'h0,        32'h0,         1'b0, ST_Z,  1'b0, 32'h0,         1'b0};
    tbl[5]  = '{"req_ack_id",      5'b01011, 32'h0,        32'h0,         1'b0, ST_ID, 1'b0, 32'h0,         1'b0};
    tbl[6]  = '{"exc_int",         5'b00000, 32'h1,        32'h0,         1'b0, ST_Z,  1'b1, 32'h20,        1'b0};
    tbl[7]  = '{"exc_8_stallreq",  5'b01100, 32'h8,        32'h0,         1'b0, ST_Z,  1'b1, 32'h40,        1'b0};
    tbl[8]  = '{"exc_a",           5'b00000, 32'ha,        32'h0,         1'b0, ST_Z,  1'b1, 32'h40,        1'b0};
    tbl[9]  = '{"exc_c",           5'b00000, 32'hc,        32'h0,         1'b0, ST_Z,  1'b1, 32'h40,        1'b0};
    tbl[10] = '{"exc_d",           5'b00000, 32'hd,        32'h0,         1'b0, ST_Z,  1'b1, 32'h40,        1'b0};
    tbl[11] = '{"exc_eret",        5'b00000, 32'he,        32'hDEAD_BEEC, 1'b0, ST_Z,  1'b1, 32'hDEAD_BEEC, 1'b0};
    tbl[12] = '{"exc_other",       5'b00000, 32'h8000_0000, 32'h0,        1'b0, ST_Z,  1'b1, 32'h40,        1'b0};
    tbl[13] = '{"exc_over_buswait",5'b00010, 32'h20,       32'h0,         1'b0, ST_Z,  1'b1, 32'h40,        1'b0};
    tbl[14] = '{"cnt_clr",         5'b00000, 32'h0,        32'h0,         1'b1, ST_Z,  1'b0, 32'h0,         1'b0};
    tbl[15] = '{"after_clr",       5'b00000, 32'h0,        32'h0,         1'b0, ST_Z,  1'b0, 32'h0,         1'b0};

    // Reset with noisy inputs: everything reads zero
    s("reset_hold", 5'b11111, 32'h1, 32'h55, 1'b0, ST_Z, 1'b0, 32'h0, 1'b0);
    s("reset_hold2", 5'b10010, 32'h0, 32'h0, 1'b0, ST_Z, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 16; i++) go(tbl[i]);

    // Ack on the 4th cycle: three held cycles then release
    s("a_wait1",    5'b00010, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("a_wait2_ex", 5'b00110, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("a_wait3",    5'b00010, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("a_ack",      5'b00011, 32'h0, 32'h0, 1'b0, ST_Z,   1'b0, 32'h0, 1'b0);
    s("a_idle",     5'b00000, 32'h0, 32'h0, 1'b0, ST_Z,   1'b0, 32'h0, 1'b0);

    // Timeout: five held cycles, one bus-error cycle ignoring mem_req
    for (int i = 0; i < 5; i++)
      s("b_wait", 5'b00010, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("b_buserr",     5'b00010, 32'h0, 32'h0, 1'b0, ST_Z,   1'b0, 32'h0, 1'b1);
    s("b_rewait",     5'b00010, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("b_release_id", 5'b01000, 32'h0, 32'h0, 1'b0, ST_ID,  1'b0, 32'h0, 1'b0);
    s("b_idle",       5'b00000, 32'h0, 32'h0, 1'b0, ST_Z,   1'b0, 32'h0, 1'b0);

    // Ack arriving in the timeout cycle wins
    for (int i = 0; i < 4; i++)
      s("c_wait", 5'b00010, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("c_ack_at_timeout", 5'b00011, 32'h0, 32'h0, 1'b0, ST_Z, 1'b0, 32'h0, 1'b0);
    s("c_idle",           5'b00000, 32'h0, 32'h0, 1'b0, ST_Z, 1'b0, 32'h0, 1'b0);

    // eret during a bus wait: flush to EPC, wait counter restarts
    for (int i = 0; i < 2; i++)
      s("d_wait", 5'b00010, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("d_eret", 5'b00010, 32'he, 32'h0000_1234, 1'b0, ST_Z, 1'b1, 32'h0000_1234, 1'b0);
    for (int i = 0; i < 5; i++)
      s("d_rewait", 5'b00010, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("d_buserr", 5'b00010, 32'h0, 32'h0, 1'b0, ST_Z, 1'b0, 32'h0, 1'b1);
    s("d_idle",   5'b00000, 32'h0, 32'h0, 1'b0, ST_Z, 1'b0, 32'h0, 1'b0);

    // Counter saturation: preload all-ones, stall, then clear
    force dut.cnt_q = 32'hFFFF_FFFF;
    cnt_model = 32'hFFFF_FFFF;
    s("sat_preload", 5'b01000, 32'h0, 32'h0, 1'b0, ST_ID, 1'b0, 32'h0, 1'b0);
    release dut.cnt_q;
    s("sat_hold",    5'b01000, 32'h0, 32'h0, 1'b0, ST_ID, 1'b0, 32'h0, 1'b0);
    s("sat_hold2",   5'b00100, 32'h0, 32'h0, 1'b0, ST_EX, 1'b0, 32'h0, 1'b0);
    s("sat_clr",     5'b01000, 32'h0, 32'h0, 1'b1, ST_ID, 1'b0, 32'h0, 1'b0);
    s("sat_cleared", 5'b00000, 32'h0, 32'h0, 1'b0, ST_Z,  1'b0, 32'h0, 1'b0);

    // Reset in the middle of a bus wait with stall count at 7
    for (int i = 0; i < 5; i++)
      s("f_id", 5'b01000, 32'h0, 32'h0, 1'b0, ST_ID, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++)
      s("f_wait", 5'b00010, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("f_rst",     5'b11110, 32'h1, 32'h0, 1'b0, ST_Z,   1'b0, 32'h0, 1'b0);
    s("f_after",   5'b00000, 32'h0, 32'h0, 1'b0, ST_Z,   1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++)
      s("f_rewait", 5'b00010, 32'h0, 32'h0, 1'b0, ST_BUS, 1'b0, 32'h0, 1'b0);
    s("f_buserr",  5'b00000, 32'h0, 32'h0, 1'b0, ST_Z,   1'b0, 32'h0, 1'b1);
    s("f_idle",    5'b00000, 32'h0, 32'h0, 1'b0, ST_Z,   1'b0, 32'h0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
